// File: rtl/jtag_1149_d10_mstr_tx_lane_dist_if.sv
// Character handshake from the TX controller into the lane distributor.
// Master drives the character stream, slave returns in_rdy.
interface jtag_1149_d10_mstr_tx_lane_dist_if #(
  parameter int BYTE_WIDTH = 8
);
  logic                  in_vld;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_k;
  logic                  in_last;
  logic                  in_rdy;

  modport master (
    output in_vld,
    output in_data,
    output in_k,
    output in_last,
    input  in_rdy
  );

  modport slave (
    input  in_vld,
    input  in_data,
    input  in_k,
    input  in_last,
    output in_rdy
  );
endinterface

// File: rtl/jtag_1149_d10_mstr_tx_lane_dist.sv
// Multi-lane TX distributor: stripes characters over 1..NUM_LANES lanes,
// buffers whole stripes, inserts idle and periodic alignment markers.
module jtag_1149_d10_mstr_tx_lane_dist #(
  parameter int NUM_LANES    = 4,
  parameter int BYTE_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int ALIGN_PERIOD = 256,
  parameter logic [BYTE_WIDTH-1:0] IDLE_CHAR  = 8'hBC,
  parameter logic [BYTE_WIDTH-1:0] ALIGN_CHAR = 8'h7C,
  localparam int LG = $clog2(NUM_LANES),
  localparam int MW = LG + 1,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1,
  localparam int CW = $clog2(ALIGN_PERIOD),
  localparam int SW = NUM_LANES * BYTE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  jtag_1149_d10_mstr_tx_lane_dist_if.slave in_if,
  input  logic [MW-1:0]        lane_mode,
  input  logic                 suspend,
  output logic                 cfg_busy,
  output logic [SW-1:0]        lane_data,
  output logic [NUM_LANES-1:0] lane_k,
  output logic [LW-1:0]        fifo_level,
  output logic                 align_tick
);

  logic [MW-1:0]         act_lg;
  logic [MW-1:0]         req_lg;
  logic [MW-1:0]         eff_lg;
  logic [MW-1:0]         eff_n;
  logic [MW-1:0]         act_n;
  logic                  apply;

  logic [MW-1:0]         gcnt;
  logic [BYTE_WIDTH-1:0] g_data [NUM_LANES];
  logic [NUM_LANES-1:0]  g_k;

  logic                  acc;
  logic                  push;
  logic                  pop;
  logic [SW-1:0]         push_d;
  logic [NUM_LANES-1:0]  push_k;

  logic [SW-1:0]         mem_d [FIFO_DEPTH];
  logic [NUM_LANES-1:0]  mem_k [FIFO_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;

  logic [CW-1:0]         align_cnt;
  logic                  align_now;

  logic [SW-1:0]         nxt_d;
  logic [NUM_LANES-1:0]  nxt_k;

  assign req_lg = (lane_mode > MW'(LG)) ? MW'(LG) : lane_mode;
  assign apply  = (req_lg != act_lg) && (gcnt == '0) &&
                  (fifo_level == '0);
  assign cfg_busy = ~rst & (req_lg != act_lg);

  // A character accepted on the switch edge already uses the new width
  assign eff_lg = apply ? req_lg : act_lg;
  assign eff_n  = MW'(1) << eff_lg;
  assign act_n  = MW'(1) << act_lg;

  assign align_now = (align_cnt == CW'(ALIGN_PERIOD - 1));
  assign pop = !align_now && !suspend && (fifo_level != '0);

  assign in_if.in_rdy = (fifo_level < LW'(FIFO_DEPTH)) || pop;
  assign acc  = in_if.in_vld && in_if.in_rdy;
  assign push = acc &&
                ((gcnt == eff_n - MW'(1)) || in_if.in_last);

  always_comb begin
    push_d = '0;
    push_k = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (MW'(i) < gcnt) begin
        push_d[i*BYTE_WIDTH +: BYTE_WIDTH] = g_data[i];
        push_k[i] = g_k[i];
      end else if (MW'(i) == gcnt) begin
        push_d[i*BYTE_WIDTH +: BYTE_WIDTH] = in_if.in_data;
        push_k[i] = in_if.in_k;
      end else begin
        push_d[i*BYTE_WIDTH +: BYTE_WIDTH] = IDLE_CHAR;
        push_k[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_lg <= '0;
    end else if (apply) begin
      act_lg <= req_lg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt <= '0;
      g_k  <= '1;
      for (int i = 0; i < NUM_LANES; i++) begin
        g_data[i] <= IDLE_CHAR;
      end
    end else if (push) begin
      gcnt <= '0;
    end else if (acc) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (gcnt == MW'(i)) begin
          g_data[i] <= in_if.in_data;
          g_k[i]    <= in_if.in_k;
        end
      end
      gcnt <= gcnt + MW'(1);
    end
  end

  // Storage needs no reset: only entries below fifo_level are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wptr] <= push_d;
      mem_k[wptr] <= push_k;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop) begin
        fifo_level <= fifo_level + LW'(1);
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_cnt <= '0;
    end else if (align_now) begin
      align_cnt <= '0;
    end else begin
      align_cnt <= align_cnt + CW'(1);
    end
  end

  always_comb begin
    nxt_d = {NUM_LANES{IDLE_CHAR}};
    nxt_k = '1;
    if (align_now) begin
      nxt_d = {NUM_LANES{ALIGN_CHAR}};
    end else if (pop) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (MW'(i) < act_n) begin
          nxt_d[i*BYTE_WIDTH +: BYTE_WIDTH] =
            mem_d[rptr][i*BYTE_WIDTH +: BYTE_WIDTH];
          nxt_k[i] = mem_k[rptr][i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_data  <= {NUM_LANES{IDLE_CHAR}};
      lane_k     <= '1;
      align_tick <= 1'b0;
    end else begin
      lane_data  <= nxt_d;
      lane_k     <= nxt_k;
      align_tick <= align_now;
    end
  end

endmodule

// File: tb/tb_jtag_1149_d10_mstr_tx_lane_dist.sv
// Directed bench for the lane distributor: stripe vector table plus
// sequences for alignment, FIFO full/drain, mode change and mid-run reset.
module tb_jtag_1149_d10_mstr_tx_lane_dist;
  localparam int NL = 4;
  localparam int BW = 8;
  localparam int FD = 8;
  localparam int AP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  lane_mode;
  logic        suspend;
  logic        cfg_busy;
  logic [31:0] lane_data;
  logic [3:0]  lane_k;
  logic [3:0]  fifo_level;
  logic        align_tick;

  always #5 clk = ~clk;

  jtag_1149_d10_mstr_tx_lane_dist_if #(.BYTE_WIDTH(BW)) bus ();

  jtag_1149_d10_mstr_tx_lane_dist #(
    .NUM_LANES(NL), .BYTE_WIDTH(BW), .FIFO_DEPTH(FD),
    .ALIGN_PERIOD(AP), .IDLE_CHAR(8'hBC), .ALIGN_CHAR(8'h7C)
  ) dut (
    .clk(clk), .rst(rst), .in_if(bus),
    .lane_mode(lane_mode), .suspend(suspend),
    .cfg_busy(cfg_busy), .lane_data(lane_data),
    .lane_k(lane_k), .fifo_level(fifo_level),
    .align_tick(align_tick)
  );

  typedef struct {
    logic [2:0]  mode;
    int          n;
    logic [31:0] bytes;
    logic [3:0]  kb;
    logic        last;
    int          ce;
    logic [31:0] ed;
    logic [3:0]  ek;
  } vec_t;

  vec_t tv[9];

  int n_chk = 0;
  int n_fail = 0;

  int m_act, m_lvl, m_slot, m_ecnt, m_next, m_total;
  logic [31:0] g_d;
  logic [3:0]  g_k;
  logic [35:0] m_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic m_init();
    m_act = 0; m_lvl = 0; m_slot = 0;
    m_ecnt = 0; m_next = 0; m_total = 0;
    m_q.delete();
    g_d = {4{8'hBC}};
    g_k = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_vld = 1'b0; bus.in_data = '0;
    bus.in_k = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_init();
  endtask

  // One clock of 4-lane-or-narrower streaming against a reference model
  task automatic mstep();
    logic vld, rdy, pop, aln, apply;
    int req, n;
    logic [7:0]  b;
    logic [35:0] ex;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
    req = (lane_mode > 3'd2) ? 2 : int'(lane_mode);
    aln = ((m_ecnt + 1) % AP) == 0;
    pop = !aln && !suspend && m_lvl > 0;
    rdy = (m_lvl < FD) || pop;
    vld = m_next < m_total;
    b = 8'(m_next + 1);
    bus.in_vld = vld; bus.in_data = b;
    bus.in_k = 1'b0; bus.in_last = 1'b0;
    #1;
    chk("in_rdy", 32'(bus.in_rdy), 32'(rdy));
    chk("cfg_busy", 32'(cfg_busy), 32'(req != m_act));
    apply = req != m_act && m_slot == 0 && m_lvl == 0;
    n = 1 << (apply ? req : m_act);
    exp_d = {4{8'hBC}};
    exp_k = 4'hF;
    if (aln) begin
      exp_d = {4{8'h7C}};
    end else if (pop) begin
      ex = m_q.pop_front();
      exp_d = ex[31:0];
      exp_k = ex[35:32];
      m_lvl--;
    end
    if (vld && rdy) begin
      g_d[m_slot*8 +: 8] = b;
      g_k[m_slot] = 1'b0;
      m_slot++;
      m_next++;
      if (m_slot == n) begin
        m_q.push_back({g_k, g_d});
        m_lvl++;
        m_slot = 0;
        g_d = {4{8'hBC}};
        g_k = 4'hF;
      end
    end
    if (apply) m_act = req;
    @(posedge clk);
    m_ecnt++;
    @(negedge clk);
    chk("lane_data", lane_data, exp_d);
    chk("lane_k", 32'(lane_k), 32'(exp_k));
    chk("align_tick", 32'(align_tick), 32'(aln));
    chk("fifo_level", 32'(fifo_level), 32'(m_lvl));
  endtask

  initial begin
    tv[0] = '{3'd2, 4, 32'h44332211, 4'b0000, 1'b0, 5, 32'h44332211, 4'b0000};
    tv[1] = '{3'd2, 4, 32'h44332211, 4'b0000, 1'b0, 4, 32'hBCBCBCBC, 4'b1111};
    tv[2] = '{3'd1, 3, 32'h00A3A2A1, 4'b0000, 1'b1, 3, 32'hBCBCA2A1, 4'b1100};
    tv[3] = '{3'd1, 3, 32'h00A3A2A1, 4'b0000, 1'b1, 4, 32'hBCBCBCA3, 4'b1110};
    tv[4] = '{3'd0, 1, 32'h00000055, 4'b0000, 1'b0, 2, 32'hBCBCBC55, 4'b1110};
    tv[5] = '{3'd2, 3, 32'h00030201, 4'b0000, 1'b1, 4, 32'hBC030201, 4'b1000};
    tv[6] = '{3'd2, 4, 32'h302010FB, 4'b0001, 1'b0, 5, 32'h302010FB, 4'b0001};
    tv[7] = '{3'd7, 4, 32'h04030201, 4'b0000, 1'b0, 5, 32'h04030201, 4'b0000};
    tv[8] = '{3'd1, 1, 32'h0000005A, 4'b0000, 1'b1, 2, 32'hBCBCBC5A, 4'b1110};

    rst = 1'b1;
    lane_mode = 3'd0;
    suspend = 1'b0;
    bus.in_vld = 1'b0; bus.in_data = '0;
    bus.in_k = 1'b0; bus.in_last = 1'b0;
    m_init();

    // Reset state and free-running alignment markers
    do_reset();
    chk("rst_data", lane_data, {4{8'hBC}});
    chk("rst_k", 32'(lane_k), 32'hF);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_tick", 32'(align_tick), 0);
    chk("rst_busy", 32'(cfg_busy), 0);
    repeat (24) mstep();

    // Stripe vector table
    for (int v = 0; v < 9; v++) begin
      do_reset();
      lane_mode = tv[v].mode;
      for (int e = 1; e <= tv[v].ce; e++) begin
        if (e <= tv[v].n) begin
          bus.in_vld  = 1'b1;
          bus.in_data = tv[v].bytes[(e-1)*8 +: 8];
          bus.in_k    = tv[v].kb[e-1];
          bus.in_last = tv[v].last && (e == tv[v].n);
        end else begin
          bus.in_vld = 1'b0;
          bus.in_last = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (e == tv[v].ce) begin
          chk($sformatf("vec%0d_data", v), lane_data, tv[v].ed);
          chk($sformatf("vec%0d_k", v), 32'(lane_k), 32'(tv[v].ek));
        end
      end
      bus.in_vld = 1'b0;
      bus.in_last = 1'b0;
    end

    // Fill FIFO under suspend, then drain around align cycles
    do_reset();
    lane_mode = 3'd2;
    suspend = 1'b1;
    m_total = 36;
    for (int i = 0; i < 50 && m_lvl < FD; i++) mstep();
    repeat (2) mstep();
    #1;
    chk("full_level", 32'(fifo_level), 8);
    chk("full_rdy", 32'(bus.in_rdy), 0);
    suspend = 1'b0;
    for (int i = 0; i < 60 && (m_lvl > 0 || m_next < m_total); i++)
      mstep();
    chk("drain_level", 32'(fifo_level), 0);
    chk("drain_bytes", 32'(m_next), 36);

    // Mode change held off while stripes are queued, then clamp
    do_reset();
    lane_mode = 3'd2;
    suspend = 1'b1;
    m_total = 12;
    for (int i = 0; i < 20 && m_next < m_total; i++) mstep();
    mstep();
    chk("cfg_level", 32'(fifo_level), 3);
    lane_mode = 3'd0;
    #1;
    chk("cfg_busy_set", 32'(cfg_busy), 1);
    suspend = 1'b0;
    for (int i = 0; i < 30 && m_act != 0; i++) mstep();
    chk("cfg_applied", 32'(m_act), 0);
    m_total = 14;
    repeat (6) mstep();
    lane_mode = 3'd7;
    m_total = 18;
    for (int i = 0; i < 20 && !(m_act == 2 && m_next == 18); i++)
      mstep();
    repeat (4) mstep();
    chk("clamp_done", 32'(m_next), 18);

    // Asynchronous reset with stripes and a partial stripe held
    do_reset();
    lane_mode = 3'd2;
    suspend = 1'b1;
    m_total = 21;
    for (int i = 0; i < 40 && m_next < m_total; i++) mstep();
    chk("pre_rst_level", 32'(fifo_level), 5);
    rst = 1'b1;
    #1;
    chk("arst_data", lane_data, {4{8'hBC}});
    chk("arst_k", 32'(lane_k), 32'hF);
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_tick", 32'(align_tick), 0);
    chk("arst_busy", 32'(cfg_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    m_init();
    suspend = 1'b0;
    m_total = 4;
    repeat (8) mstep();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
